memory_embedded_arbiter: RTL and testbench

- Two-requester arbiter and sequencer in front of one single-port memory_embedded instance (1-cycle read latency: address sampled at clock edge, q valid the following cycle).
- Lets two clients share one BRAM at full throughput, e.g. cache lookup stage and line fill/writeback engine.
- Supports locked bursts so a client can own the RAM for a whole line transfer, with a bounded lock length to cap starvation.

---
 rtl/memory_embedded_arbiter.sv | 168 ++++++++++++++++
 tb/tb_memory_embedded_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_embedded_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : memory_embedded_arbiter
// Function : Two-requester arbiter/sequencer in front of one single-port,
//            1-cycle-latency memory_embedded RAM, with bounded locked bursts.
// Option   : MEMORY_ARBITER_ROUND_ROBIN_EN -- round-robin IDLE contention
//            (undefined: port 0 wins IDLE contention).
// Revision : 1.0
// ============================================================================
module memory_embedded_arbiter #(
  parameter int N_ENTRIES = 1024,
  parameter int BW_DATA   = 32,
  parameter int BW_ADDR   = $clog2(N_ENTRIES),
  parameter int MAX_LOCK  = 16
) (
  input  logic               clock_i,
  input  logic               resetn_i,
  input  logic [1:0]         req_i,
  input  logic [1:0]         wren_i,
  input  logic [1:0]         lock_i,
  input  logic [BW_ADDR-1:0] addr0_i,
  input  logic [BW_ADDR-1:0] addr1_i,
  input  logic [BW_DATA-1:0] data0_i,
  input  logic [BW_DATA-1:0] data1_i,
  output logic [1:0]         ready_o,
  output logic [1:0]         rvalid_o,
  output logic [BW_DATA-1:0] rdata_o,
  output logic               mem_wren_o,
  output logic [BW_ADDR-1:0] mem_addr_o,
  output logic [BW_DATA-1:0] mem_data_o,
  input  logic [BW_DATA-1:0] mem_data_i
);

  localparam int                BW_CNT    = $clog2(MAX_LOCK + 1);
  localparam logic [BW_CNT-1:0] LOCK_LOAD = BW_CNT'(MAX_LOCK - 1);
  localparam logic [BW_CNT-1:0] CNT_ONE   = BW_CNT'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [BW_CNT-1:0] lock_cnt_q, lock_cnt_d;
  logic [1:0]        rvalid_q, rvalid_d;
  logic [1:0]        grant;
  logic              prefer_port1;

`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
  logic rr_q, rr_d;
  assign prefer_port1 = rr_q;
`else
  assign prefer_port1 = 1'b0;
`endif

  // Grant is gated by the raw reset so nothing reaches the RAM while in reset.
  always_comb begin
    grant = 2'b00;
    if (resetn_i) begin
      case (state_q)
        IDLE: begin
          if (req_i == 2'b11) grant = prefer_port1 ? 2'b10 : 2'b01;
          else                grant = req_i;
        end
        OWN0:    grant = {1'b0, req_i[0]};
        OWN1:    grant = {req_i[1], 1'b0};
        default: grant = 2'b00;
      endcase
    end
  end

  assign ready_o  = req_i & grant;
  assign rvalid_o = rvalid_q;
  assign rdata_o  = mem_data_i;

  always_comb begin
    mem_wren_o = 1'b0;
    mem_addr_o = '0;
    mem_data_o = '0;
    if (grant[0]) begin
      mem_wren_o = wren_i[0];
      mem_addr_o = addr0_i;
      mem_data_o = data0_i;
    end else if (grant[1]) begin
      mem_wren_o = wren_i[1];
      mem_addr_o = addr1_i;
      mem_data_o = data1_i;
    end
  end

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    rvalid_d   = grant & ~wren_i;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
    rr_d       = rr_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant[0]) begin
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
          rr_d = 1'b1;
`endif
          if (lock_i[0]) begin
            state_d    = OWN0;
            lock_cnt_d = LOCK_LOAD;
          end
        end else if (grant[1]) begin
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
          rr_d = 1'b0;
`endif
          if (lock_i[1]) begin
            state_d    = OWN1;
            lock_cnt_d = LOCK_LOAD;
          end
        end
      end
      // Owner keeps the RAM until it drops lock or the cycle budget runs out.
      OWN0: begin
        if (!lock_i[0] || (lock_cnt_q == '0)) begin
          state_d    = IDLE;
          lock_cnt_d = '0;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
          rr_d       = 1'b1;
`endif
        end else begin
          lock_cnt_d = lock_cnt_q - CNT_ONE;
        end
      end
      OWN1: begin
        if (!lock_i[1] || (lock_cnt_q == '0)) begin
          state_d    = IDLE;
          lock_cnt_d = '0;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
          rr_d       = 1'b0;
`endif
        end else begin
          lock_cnt_d = lock_cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d    = IDLE;
        lock_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q    <= IDLE;
      lock_cnt_q <= '0;
      rvalid_q   <= 2'b00;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
      rr_q       <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      rvalid_q   <= rvalid_d;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
      rr_q       <= rr_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_memory_embedded_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_memory_embedded_arbiter
// Function : Self-checking bench for memory_embedded_arbiter with a
//            behavioural RAM and an ownership/budget reference model.
// Revision : 1.0
// ============================================================================
module tb_memory_embedded_arbiter;

  localparam int N        = 64;
  localparam int BW_DATA  = 32;
  localparam int BW_ADDR  = 6;
  localparam int MAX_LOCK = 4;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic               clk    = 1'b0;
  logic               resetn = 1'b0;
  logic [1:0]         req, wren, lock;
  logic [BW_ADDR-1:0] a0, a1;
  logic [BW_DATA-1:0] d0, d1;
  logic [1:0]         ready, rvalid;
  logic [BW_DATA-1:0] rdata, mem_data_o, mem_data_i;
  logic               mem_wren;
  logic [BW_ADDR-1:0] mem_addr;

  always #5 clk = ~clk;

  memory_embedded_arbiter #(
    .N_ENTRIES(N), .BW_DATA(BW_DATA), .BW_ADDR(BW_ADDR), .MAX_LOCK(MAX_LOCK)
  ) dut (
    .clock_i(clk), .resetn_i(resetn),
    .req_i(req), .wren_i(wren), .lock_i(lock),
    .addr0_i(a0), .addr1_i(a1), .data0_i(d0), .data1_i(d1),
    .ready_o(ready), .rvalid_o(rvalid), .rdata_o(rdata),
    .mem_wren_o(mem_wren), .mem_addr_o(mem_addr), .mem_data_o(mem_data_o),
    .mem_data_i(mem_data_i)
  );

  // Behavioural single-port RAM, 1-cycle read latency; unwritten words read a pattern.
  logic [BW_DATA-1:0] ram [N];
  bit                 written [N];
  always @(posedge clk) begin
    mem_data_i <= written[mem_addr] ? ram[mem_addr] : (32'hA500_0000 | 32'(mem_addr));
    if (mem_wren) begin
      ram[mem_addr]     <= mem_data_o;
      written[mem_addr] <= 1'b1;
    end
  end

  // Reference model: owner port (-1 = none), remaining OWN cycles, preferred port.
  int                 m_owner, m_budget, m_pref;
  logic [1:0]         m_rv;
  logic [BW_DATA-1:0] m_rdata;
  logic [BW_DATA-1:0] m_mem [N];
  int                 checks = 0;
  int                 errors = 0;

  function automatic int model_grant();
    if (!resetn) return -1;
    if (m_owner >= 0) return req[m_owner] ? m_owner : -1;
    if (req == 2'b11) return RR ? m_pref : 0;
    if (req[0]) return 0;
    if (req[1]) return 1;
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner  = -1;
    m_budget = 0;
    m_pref   = 0;
    m_rv     = 2'b00;
  endtask

  task automatic model_check();
    int g;
    logic [1:0] er;
    logic ew;
    logic [BW_ADDR-1:0] ea;
    logic [BW_DATA-1:0] ed;
    g = model_grant();
    er = 2'b00; ew = 1'b0; ea = '0; ed = '0;
    if (g == 0) begin er = 2'b01; ew = wren[0]; ea = a0; ed = d0; end
    if (g == 1) begin er = 2'b10; ew = wren[1]; ea = a1; ed = d1; end
    chk("ready", 32'(ready), 32'(er));
    chk("mem_wren", 32'(mem_wren), 32'(ew));
    chk("mem_addr", 32'(mem_addr), 32'(ea));
    chk("mem_data", mem_data_o, ed);
    chk("rvalid", 32'(rvalid), 32'(m_rv));
    if (m_rv != 2'b00) chk("rdata", rdata, m_rdata);
  endtask

  task automatic model_update();
    int g;
    logic [BW_ADDR-1:0] ad;
    logic [BW_DATA-1:0] dt;
    if (!resetn) begin
      model_reset();
      return;
    end
    g = model_grant();
    m_rv = 2'b00;
    if (g >= 0) begin
      ad = (g == 0) ? a0 : a1;
      dt = (g == 0) ? d0 : d1;
      if (wren[g]) m_mem[ad] = dt;
      else begin
        m_rv    = (g == 0) ? 2'b01 : 2'b10;
        m_rdata = m_mem[ad];
      end
    end
    if (m_owner >= 0) begin
      if (!lock[m_owner] || m_budget == 1) begin
        m_pref  = 1 - m_owner;
        m_owner = -1;
      end else begin
        m_budget--;
      end
    end else if (g >= 0) begin
      m_pref = 1 - g;
      if (lock[g]) begin
        m_owner  = g;
        m_budget = MAX_LOCK;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic cyc(input logic [1:0] r, input logic [1:0] w, input logic [1:0] l,
                     input logic [BW_ADDR-1:0] x0, input logic [BW_ADDR-1:0] x1,
                     input logic [BW_DATA-1:0] y0, input logic [BW_DATA-1:0] y1);
    req = r; wren = w; lock = l; a0 = x0; a1 = x1; d0 = y0; d1 = y1;
    #1;
    model_check();
  endtask

  task automatic apply_reset();
    resetn = 1'b0;
    req = 2'b00; wren = 2'b00; lock = 2'b00;
    a0 = '0; a1 = '0; d0 = '0; d1 = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  typedef struct {
    logic [1:0]         req, wren, lock;
    logic [BW_ADDR-1:0] a0, a1;
    logic [BW_DATA-1:0] d0;
    logic [1:0]         rdy_fx, rdy_rr, rv_fx, rv_rr;
    bit                 chk_rd;
    logic [BW_DATA-1:0] rd;
  } vec_t;

  vec_t tbl [11];

  initial begin
    logic [1:0] er, ev;
    logic [BW_ADDR-1:0] ea;
    logic ew;

    for (int i = 0; i < N; i++) m_mem[i] = 32'hA500_0000 | 32'(i);

    tbl[0]  = '{2'b00, 2'b00, 2'b00, 6'd0, 6'd0, 32'h0,        2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 32'h0};
    tbl[1]  = '{2'b01, 2'b01, 2'b00, 6'd5, 6'd0, 32'hDEADBEEF, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0, 32'h0};
    tbl[2]  = '{2'b01, 2'b00, 2'b00, 6'd5, 6'd0, 32'h0,        2'b01, 2'b01, 2'b00, 2'b00, 1'b0, 32'h0};
    tbl[3]  = '{2'b00, 2'b00, 2'b00, 6'd5, 6'd0, 32'h0,        2'b00, 2'b00, 2'b01, 2'b01, 1'b1, 32'hDEADBEEF};
    tbl[4]  = '{2'b11, 2'b00, 2'b00, 6'd1, 6'd2, 32'h0,        2'b01, 2'b10, 2'b00, 2'b00, 1'b0, 32'h0};
    tbl[5]  = '{2'b11, 2'b00, 2'b00, 6'd1, 6'd2, 32'h0,        2'b01, 2'b01, 2'b01, 2'b10, 1'b0, 32'h0};
    tbl[6]  = '{2'b11, 2'b00, 2'b00, 6'd1, 6'd2, 32'h0,        2'b01, 2'b10, 2'b01, 2'b01, 1'b0, 32'h0};
    tbl[7]  = '{2'b11, 2'b00, 2'b00, 6'd1, 6'd2, 32'h0,        2'b01, 2'b01, 2'b01, 2'b10, 1'b0, 32'h0};
    tbl[8]  = '{2'b00, 2'b00, 2'b00, 6'd9, 6'd10, 32'h0,       2'b00, 2'b00, 2'b01, 2'b01, 1'b1, 32'hA500_0001};
    tbl[9]  = '{2'b00, 2'b00, 2'b00, 6'd9, 6'd10, 32'h0,       2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 32'h0};
    tbl[10] = '{2'b00, 2'b00, 2'b00, 6'd9, 6'd10, 32'h0,       2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 32'h0};

    apply_reset();

    for (int i = 0; i < 11; i++) begin
      cyc(tbl[i].req, tbl[i].wren, tbl[i].lock, tbl[i].a0, tbl[i].a1, tbl[i].d0, 32'h1111_1111);
      er = RR ? tbl[i].rdy_rr : tbl[i].rdy_fx;
      ev = RR ? tbl[i].rv_rr : tbl[i].rv_fx;
      ea = (er == 2'b01) ? tbl[i].a0 : (er == 2'b10) ? tbl[i].a1 : '0;
      ew = (er == 2'b01) ? tbl[i].wren[0] : (er == 2'b10) ? tbl[i].wren[1] : 1'b0;
      chk("tbl_ready", 32'(ready), 32'(er));
      chk("tbl_rvalid", 32'(rvalid), 32'(ev));
      chk("tbl_addr", 32'(mem_addr), 32'(ea));
      chk("tbl_wren", 32'(mem_wren), 32'(ew));
      if (tbl[i].chk_rd) chk("tbl_rdata", rdata, tbl[i].rd);
      tick();
    end

    // Port 1 locked burst while port 0 keeps requesting, then lock dropped.
    apply_reset();
    cyc(2'b10, 2'b00, 2'b10, 6'd7, 6'd8, 0, 0); chk("burst_start", 32'(ready), 32'h2); tick();
    cyc(2'b11, 2'b00, 2'b10, 6'd7, 6'd9, 0, 0); chk("burst_hold1", 32'(ready), 32'h2); tick();
    cyc(2'b11, 2'b00, 2'b10, 6'd7, 6'd10, 0, 0); chk("burst_hold2", 32'(ready), 32'h2); tick();
    cyc(2'b11, 2'b00, 2'b00, 6'd7, 6'd11, 0, 0); chk("burst_drop", 32'(ready), 32'h2); tick();
    cyc(2'b11, 2'b00, 2'b00, 6'd7, 6'd12, 0, 0); chk("burst_after", 32'(ready), 32'h1); tick();
    cyc(2'b00, 2'b00, 2'b00, 6'd0, 6'd0, 0, 0); tick();

    // Port 0 holds lock forever: budget of MAX_LOCK OWN cycles forces a release.
    apply_reset();
    cyc(2'b01, 2'b00, 2'b01, 6'd20, 6'd21, 0, 0); chk("force_enter", 32'(ready), 32'h1); tick();
    for (int k = 0; k < MAX_LOCK; k++) begin
      cyc(2'b11, 2'b00, 2'b01, 6'(22 + k), 6'd30, 0, 0); chk("force_own", 32'(ready), 32'h1); tick();
    end
    cyc(2'b11, 2'b00, 2'b01, 6'd26, 6'd31, 0, 0);
    chk("force_release", 32'(ready), RR ? 32'h2 : 32'h1); tick();
    cyc(2'b11, 2'b00, 2'b01, 6'd27, 6'd32, 0, 0); chk("force_next", 32'(ready), 32'h1); tick();
    cyc(2'b00, 2'b00, 2'b00, 6'd0, 6'd0, 0, 0); tick();

    // Reset just after an accepted read: the pending rvalid must never appear.
    apply_reset();
    cyc(2'b01, 2'b00, 2'b00, 6'd3, 6'd4, 0, 0); chk("rst_accept", 32'(ready), 32'h1);
    @(posedge clk);
    model_update();
    #1 resetn = 1'b0;
    model_reset();
    #1;
    chk("rst_rvalid", 32'(rvalid), 32'h0);
    chk("rst_ready", 32'(ready), 32'h0);
    chk("rst_wren", 32'(mem_wren), 32'h0);
    @(negedge clk);
    req = 2'b11; wren = 2'b11;
    #1;
    model_check();
    chk("rst_hold_ready", 32'(ready), 32'h0);
    chk("rst_hold_wren", 32'(mem_wren), 32'h0);
    @(posedge clk);
    model_update();
    @(negedge clk);
    resetn = 1'b1; req = 2'b00; wren = 2'b00;
    #1;
    model_check();
    chk("rst_after_rvalid", 32'(rvalid), 32'h0);
    tick();
    cyc(2'b10, 2'b00, 2'b00, 6'd3, 6'd4, 0, 0); chk("rst_fresh_p1", 32'(ready), 32'h2); tick();
    cyc(2'b00, 2'b00, 2'b00, 6'd0, 6'd0, 0, 0); chk("rst_fresh_rv", 32'(rvalid), 32'h2); tick();

    // Randomized traffic with sticky locks, checked every cycle by the model.
    apply_reset();
    lock = 2'b00;
    for (int n = 0; n < 3000; n++) begin
      logic [1:0] l;
      l = lock;
      if ($urandom_range(0, 7) == 0) l = 2'($urandom);
      cyc({1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0)},
          2'($urandom), l, 6'($urandom), 6'($urandom), $urandom, $urandom);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
